// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [ADDR_W-1:0] ROM_BASE     = 32'hBFC0_0000;
    localparam logic [ADDR_W-1:0] ROM_LIMIT    = 32'hBFC0_0FFF;

    typedef enum logic [0:0] {
        Run,
        Fault
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer; flush beats push, pop on empty is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CntW   = $clog2(DEPTH + 1),
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [CntW-1:0] count_o,
    output entry_t          head_o,
    output logic            full_o,
    output logic            empty_o
);

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW-1:0] wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    // A full buffer can still accept a word when the head leaves this cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_push && !flush_i) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, checks the ROM window and feeds decode from a prefetch buffer.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned                   ADDRESS_WIDTH     = 32,
    parameter int unsigned                   INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]      RESET_VECTOR      = fetch_pkg::RESET_VECTOR,
    parameter logic [ADDRESS_WIDTH-1:0]      ROM_BASE          = fetch_pkg::ROM_BASE,
    parameter logic [ADDRESS_WIDTH-1:0]      ROM_LIMIT         = fetch_pkg::ROM_LIMIT,
    parameter int unsigned                   FIFO_DEPTH        = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_target,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_out,
    output logic [ADDRESS_WIDTH-1:0]     instr_pc,
    output logic                         fetch_fault
);

    localparam int unsigned ExtW = ADDRESS_WIDTH + 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
    } slot_t;

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ExtW-1:0]          pc_ext;
    logic [ExtW-1:0]          last_byte;
    logic                     addr_ok;
    logic                     push;
    logic                     pop;
    slot_t                    push_data;
    slot_t                    head;
    logic [CntW-1:0]          fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Window check is done one bit wider so a PC near the top of memory cannot wrap into range.
    assign pc_ext    = {1'b0, pc_q};
    assign last_byte = pc_ext + ExtW'(INSTR_BYTES - 1);
    assign addr_ok   = (pc_q[1:0] == 2'b00)
                    && (pc_ext >= {1'b0, ROM_BASE})
                    && (last_byte <= {1'b0, ROM_LIMIT});

    assign pop  = instr_valid && instr_ready;
    assign push = (state_q == Run) && !redirect_valid && addr_ok && (!fifo_full || pop);

    assign push_data = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = Run;
            pc_d    = redirect_target;
        end else if (state_q == Run) begin
            if (!addr_ok) begin
                state_d = Fault;
            end else if (push) begin
                pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Run;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (slot_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .count_o (fifo_count),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;
    assign fetch_fault = (state_q == Fault);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CntW'(FIFO_DEPTH));

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer wrapped around the byte-addressed, asynchronous-read instruction ROM.
- Owns the fetch PC and drives the ROM address each cycle.
- Captures the returned big-endian-assembled 32-bit word into a 2-entry prefetch buffer, and presents it to decode with a valid/ready handshake.
- Handles control-flow redirects (flush) and faults on misaligned or out-of-window fetch addresses.

Parameters:
- ADDRESS_WIDTH, 32, width of the PC and ROM address.
- INSTRUCTION_WIDTH, 32, width of the instruction word.
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset.
- ROM_BASE, 32'hBFC00000, lowest valid byte address of the ROM window.
- ROM_LIMIT, 32'hBFC00FFF, highest valid byte address of the ROM window.
- FIFO_DEPTH, 2, number of prefetch buffer entries; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDRESS_WIDTH  ROM byte address; equals fetch_pc combinationally.
- imem_rdata  in  INSTRUCTION_WIDTH  ROM read word; valid in the same cycle as imem_addr.
- redirect_valid  in  1  redirect fetch to redirect_target; flushes the buffer.
- redirect_target  in  ADDRESS_WIDTH  new fetch address.
- instr_valid  out  1  head-of-buffer entry is valid.
- instr_ready  in  1  decode accepts the head entry this cycle.
- instr_out  out  INSTRUCTION_WIDTH  head instruction word.
- instr_pc  out  ADDRESS_WIDTH  PC of the head instruction.
- fetch_fault  out  1  sticky fault indication; fetching is stopped while asserted.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_VECTOR, buffer empty, state=RUN.
  - instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0.
- States:
  - RUN: fetching.
  - FAULT: not fetching; the buffer still drains.
- pop = instr_valid && instr_ready.
- addr_ok = (fetch_pc[1:0]==0) && fetch_pc ≥ ROM_BASE && fetch_pc+3 ≤ ROM_LIMIT. Compute in ADDRESS_WIDTH+1 bits so it cannot wrap.
- push = state==RUN && !redirect_valid && addr_ok && (count<FIFO_DEPTH || pop).
- On push:
  - Enqueue {fetch_pc, imem_rdata}.
  - fetch_pc += 4.
  - The entry is visible at the head on the next cycle if the buffer was empty, so fetch-to-valid latency is 1 cycle.
- Push and pop in the same cycle when full are allowed; count is unchanged.
- When count==FIFO_DEPTH and there is no pop: hold fetch_pc; imem_addr stays stable.
- RUN→FAULT: state==RUN, !redirect_valid, !addr_ok. fetch_fault=1 from the next cycle; fetch_pc holds the faulting address.
- FAULT→RUN: redirect_valid with any target. State returns to RUN and fetch_fault clears next cycle. If the target is itself bad, the block re-faults one cycle later.
- Redirect (either state, highest priority):
  - Next cycle: buffer empty, fetch_pc=redirect_target, no push this cycle.
  - A pop in the same cycle as a redirect is still a completed handshake: decode consumed the old head. The buffer is then flushed regardless.
- Redirects in consecutive cycles: the last one wins. Each redirect flushes; no instruction is fetched until the first cycle without a redirect.
- Last ROM word: fetch at ROM_LIMIT-3 succeeds. The next fetch_pc is out of window, giving a fault with no wrap to ROM_BASE.
- instr_out and instr_pc hold their value while instr_valid=1 and instr_ready=0. Decode must see stable data under backpressure.
- fetch_fault has no effect on entries already buffered; they are delivered in order.
- Reset asserted mid-operation: immediate return to reset values, including discarding buffered entries.

Decomposition:
- fetch_pkg:
  - fetch_state_e enum {RUN, FAULT}.
  - fetch_entry_t struct {pc, instr}.
  - Constants: ROM_BASE, ROM_LIMIT, RESET_VECTOR, INSTR_BYTES=4.
- Sub-module fetch_fifo:
  - Parameterised by DEPTH and fetch_entry_t.
  - Ports: push, pop, flush, count, head, full, empty.
  - Same clk/rst_n.
  - flush takes priority over push; pop is ignored when empty.
- fetch_ctrl holds fetch_pc, the state FSM, addr_ok and the push/redirect logic.

Test Plan:
- Reset release, ROM words W0,W1,W2 at BFC00000/4/8, instr_ready=1 → instr_valid=1 from cycle 1. PCs BFC00000,BFC00004,BFC00008 appear on consecutive cycles, instr_out=W0,W1,W2.
- instr_ready=0 for 5 cycles after reset → count saturates at 2 and imem_addr holds at BFC00008. instr_out stays W0. On release, W0,W1,W2 are delivered in order with no gap.
- Redirect to BFC00100 while 2 entries are buffered → next cycle instr_valid=0, imem_addr=BFC00100. The cycle after: instr_pc=BFC00100, no stale W1.
- Redirect to BFC00102 (misaligned) → fetch_fault=1 two cycles later and no push. Redirect to BFC00000 → fault clears next cycle and fetch resumes at BFC00000.
- Redirect to BFC00FF8 with ready=1 → instrs at FF8 and FFC delivered, then fetch_fault=1. imem_addr holds BFC01000 and there is no wrap.
- Assert rst_n=0 mid-stream with 2 entries buffered → instr_valid and fetch_fault drop immediately. After release, the first instr_pc is BFC00000.
